// File: rtl/score_display_driver.sv
// score_display_driver: captures a binary score, converts it to packed BCD with a
// sequential double-dabble engine (one bit per clock) and drives NUM_DIGITS
// active-low seven-segment digits. Supports leading-zero blanking and saturates
// to all nines when the score does not fit. Displayed outputs only change on the
// commit cycle, so the previous value stays steady while a conversion runs.
module score_display_driver #(
  parameter int BIN_WIDTH     = 20,
  parameter int NUM_DIGITS    = 6,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    load,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [8*NUM_DIGITS-1:0] segs
);

  // Number of BCD nibbles needed to hold 2^BIN_WIDTH-1, never fewer than NUM_DIGITS
  function automatic int calc_work_digits();
    logic [BIN_WIDTH+3:0] v;
    int                   n;
    v = {4'b0000, {BIN_WIDTH{1'b1}}};
    n = 0;
    for (int i = 0; i < BIN_WIDTH; i++) begin
      if (v != '0) begin
        v = v / (BIN_WIDTH+4)'(10);
        n = n + 1;
      end else begin
        n = n;
      end
    end
    if (n < NUM_DIGITS) begin
      n = NUM_DIGITS;
    end else begin
      n = n;
    end
    return n;
  endfunction

  localparam int WORK_DIGITS = calc_work_digits();
  localparam int WW          = 4 * WORK_DIGITS;
  // Comparison width wide enough for both the input and 10^NUM_DIGITS-1
  localparam int CW          = (BIN_WIDTH > 4*NUM_DIGITS) ? BIN_WIDTH : 4*NUM_DIGITS;
  localparam int CNT_W       = $clog2(BIN_WIDTH + 1);

  // Largest displayable value, 10^NUM_DIGITS-1
  function automatic logic [CW-1:0] calc_max_val();
    logic [CW-1:0] r;
    r = CW'(1);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r = r * CW'(10);
    end
    return r - CW'(1);
  endfunction

  localparam logic [CW-1:0]    MAX_VAL  = calc_max_val();
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);

  // Active-low segment pattern for one BCD digit; impossible codes go dark
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Full segment image for a BCD word, blanking zero digits above the leading digit
  function automatic logic [8*NUM_DIGITS-1:0] render(input logic [4*NUM_DIGITS-1:0] b);
    logic [8*NUM_DIGITS-1:0] r;
    logic                    zero_above;
    r          = '1;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (b[4*k +: 4] == 4'd0);
      if ((BLANK_LEADING != 0) && (k != 0) && zero_above) begin
        r[8*k +: 8] = 8'hFF;
      end else begin
        r[8*k +: 8] = seg_decode(b[4*k +: 4]);
      end
    end
    return r;
  endfunction

  localparam logic [8*NUM_DIGITS-1:0] SEGS_RST = render('0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                  state_q,    state_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;
  logic                    ovf_pend_q, ovf_pend_d;
  logic                    overflow_q, overflow_d;
  logic [BIN_WIDTH-1:0]    bin_q,      bin_d;
  logic [WW-1:0]           work_q,     work_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;
  logic [4*NUM_DIGITS-1:0] bcd_q,      bcd_d;
  logic [8*NUM_DIGITS-1:0] segs_q,     segs_d;

  logic [WW-1:0]           adj_s;
  logic [WW-1:0]           work_shift_s;
  logic [BIN_WIDTH-1:0]    bin_shift_s;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {work, bin} left
  always_comb begin
    adj_s = work_q;
    for (int k = 0; k < WORK_DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj_s[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end else begin
        adj_s[4*k +: 4] = work_q[4*k +: 4];
      end
    end
    work_shift_s = {adj_s[WW-2:0], bin_q[BIN_WIDTH-1]};
    bin_shift_s  = {bin_q[BIN_WIDTH-2:0], 1'b0};
  end

  // Next-state and datapath control for the capture/convert/commit sequence
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    bin_d      = bin_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    segs_d     = segs_q;
    case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          // Cycle after the done pulse: drop busy before taking new loads
          busy_d = 1'b0;
        end else if (load) begin
          bin_d      = value;
          work_d     = '0;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          ovf_pend_d = (CW'(value) > MAX_VAL);
          state_d    = S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        work_d = work_shift_s;
        bin_d  = bin_shift_s;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_CONVERT;
        end
      end
      S_COMMIT: begin
        if (ovf_pend_q) begin
          bcd_d = {NUM_DIGITS{4'h9}};
        end else begin
          bcd_d = work_q[4*NUM_DIGITS-1:0];
        end
        segs_d     = render(bcd_d);
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any conversion in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      bin_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      segs_q     <= SEGS_RST;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      segs_q     <= segs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd      = bcd_q;
  assign segs     = segs_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Scoreboard bench for score_display_driver: a driver issues loads and pushes the
// expected display (computed from decimal arithmetic) into a queue; a monitor
// compares every cycle and pops on the expected done cycle.
module tb_score_display_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] value;
  logic        load;

  logic        busy,  done,  overflow;
  logic [23:0] bcd;
  logic [47:0] segs;
  logic        busy_nb, done_nb, overflow_nb;
  logic [23:0] bcd_nb;
  logic [47:0] segs_nb;

  score_display_driver #(.BIN_WIDTH(20), .NUM_DIGITS(6), .BLANK_LEADING(1)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .segs(segs)
  );

  score_display_driver #(.BIN_WIDTH(20), .NUM_DIGITS(6), .BLANK_LEADING(0)) dut_nb (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .busy(busy_nb), .done(done_nb), .overflow(overflow_nb), .bcd(bcd_nb), .segs(segs_nb)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [23:0] bcd;
    logic        ovf;
    logic [47:0] segs;
    logic [47:0] segs_nb;
  } exp_t;

  exp_t sb_q[$];
  exp_t shown;
  int   edge_cnt  = 0;
  int   next_free = 0;
  int   n_vec     = 0;
  int   n_err     = 0;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [23:0] model_bcd(input int v);
    logic [23:0] r;
    int          p;
    r = 24'h0;
    p = 1;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = (v > 999999) ? 4'd9 : 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [47:0] model_segs(input int v, input bit blank);
    logic [47:0] r;
    int          p;
    r = 48'h0;
    p = 1;
    for (int k = 0; k < 6; k++) begin
      if (v > 999999)                  r[8*k +: 8] = 8'h90;
      else if (blank && k > 0 && v < p) r[8*k +: 8] = 8'hFF;
      else                             r[8*k +: 8] = seg_tbl[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input int v, input int due);
    exp_t e;
    e.due     = due;
    e.bcd     = model_bcd(v);
    e.ovf     = (v > 999999);
    e.segs    = model_segs(v, 1'b1);
    e.segs_nb = model_segs(v, 1'b0);
    return e;
  endfunction

  // One cycle of stimulus; the model accepts a load 23 edges after the previous one
  task automatic step(input logic ld, input int val);
    int   e;
    logic acc;
    load  = ld;
    value = 20'(val);
    e     = edge_cnt + 1;
    acc   = ld && (e >= next_free);
    @(posedge clock);
    #1;
    if (acc) begin
      next_free = e + 23;
      sb_q.push_back(make_exp(val, e + 21));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    load      = 1'b0;
    sb_q.delete();
    next_free = 0;
    shown     = make_exp(0, 0);
    #1;
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_bcd",      bcd,      24'h0);
    check("rst_segs",     segs,     48'hFFFF_FFFF_FFC0);
    check("rst_segs_nb",  segs_nb,  48'hC0C0_C0C0_C0C0);
    check("rst_done_nb",  done_nb,  1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares outputs of both instances against the scoreboard every cycle
  always @(negedge clock) begin
    if (reset) begin
      logic exp_busy, exp_done;
      exp_busy = (sb_q.size() != 0);
      exp_done = (sb_q.size() != 0) && (sb_q[0].due == edge_cnt);
      check("done",    done,    exp_done);
      check("done_nb", done_nb, exp_done);
      check("busy",    busy,    exp_busy);
      check("busy_nb", busy_nb, exp_busy);
      if (exp_done) shown = sb_q.pop_front();
      check("bcd",         bcd,         shown.bcd);
      check("overflow",    overflow,    shown.ovf);
      check("segs",        segs,        shown.segs);
      check("bcd_nb",      bcd_nb,      shown.bcd);
      check("overflow_nb", overflow_nb, shown.ovf);
      check("segs_nb",     segs_nb,     shown.segs_nb);
    end
  end

  initial begin
    int sel, v;
    reset = 1'b0;
    load  = 1'b0;
    value = 20'h0;
    shown = make_exp(0, 0);
    @(posedge clock);
    #1;
    do_reset();

    step(1'b1, 154);     idle(25);
    step(1'b1, 1000000); idle(25);
    step(1'b1, 999999);  idle(25);
    step(1'b1, 154);     idle(4);
    step(1'b1, 777);     idle(25);
    step(1'b1, 7);       idle(25);
    step(1'b1, 0);       idle(25);
    step(1'b1, 1048575); idle(25);
    step(1'b1, 10);      idle(21);
    step(1'b1, 100000);  idle(25);
    step(1'b1, 123456);  idle(9);
    do_reset();
    step(1'b1, 42);      idle(25);

    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom_range(0, 1048575);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(999980, 1000020);
        default: v = $urandom_range(0, 99999);
      endcase
      step(($urandom_range(0, 3) == 0), v);
    end
    idle(30);
    check("drain", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
